mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Parametrised memory controller between the core's memory clients (instruction fetch, load/store buffer, ...) and the byte-wide RAM/IO port. It arbitrates NUM_CH request channels round-robin and serialises each granted access into 1, 2 or 4 byte cycles. Loads return zero- or sign-extended results; stores complete byte-serially. A flush aborts in-flight reads on flushable channels, and IO writes stall on io_buffer_full.

## Interface
Parameters:
- NUM_CH, 2: request channels; ch0 = ifetch, ch1 = LSB by convention.
- ADDR_WIDTH, 32: address width.
- VAL_WIDTH, 32: data width; fixed at 4 bytes.
- FLUSH_MASK, {NUM_CH{1'b1}}: bit i set means channel i reads abort on clear_in.

Ports:
- clk  in  1  clock.
- rst_in  in  1  asynchronous, active-high reset.
- rdy_in  in  1  global enable; low freezes all state and outputs.
- clear_in  in  1  misprediction flush from ROB.
- ch_req_valid  in  NUM_CH  request pending; held until matching ch_resp_valid.
- ch_req_wr  in  NUM_CH  1 = store.
- ch_req_size  in  2*NUM_CH  0 = byte, 1 = half, 2 = word.
- ch_req_signed  in  NUM_CH  sign-extend load result.
- ch_req_addr  in  ADDR_WIDTH*NUM_CH  byte address.
- ch_req_wdata  in  VAL_WIDTH*NUM_CH  store data, low bytes used.
- ch_resp_valid  out  NUM_CH  one-cycle completion pulse.
- ch_resp_data  out  VAL_WIDTH  load result; valid with ch_resp_valid.
- mem_din  in  8  RAM read byte, valid one cycle after its address.
- mem_dout  out  8  RAM write byte.
- mem_a  out  ADDR_WIDTH  RAM address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE:
  - Round-robin arbiter grants one valid channel, searching from last_grant+1.
  - Latch addr, size, signed and wdata; N = 1, 2 or 4 bytes.
  - Go to RD or WR.
- RD: for k = 0..N-1, drive mem_a = addr+k, mem_wr = 0.
  - Byte k is sampled from mem_din one cycle later into data[8k+7:8k].
  - One extra sample cycle follows the last address.
  - Then go to DONE.
- WR: for k = 0..N-1, drive mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1. Then go to DONE.
- IO stall: an address with addr[17:16] == 2'b11 is IO. If the WR state is entered on an IO address while io_buffer_full = 1, hold mem_wr = 0 and do not advance.
- DONE: pulse ch_resp_valid[grant] for one cycle and drive ch_resp_data.
  - Load result: size 0 gives data[7:0]; size 1 gives data[15:0]; extended by sign when signed = 1, else by zeros.
  - Store: resp_data = 0.
  - Return to IDLE. last_grant = grant.
- Idle RAM port: mem_wr = 0, mem_a = 0.
- Flush: on clear_in = 1 during RD or DONE with FLUSH_MASK[grant] set, go to IDLE with no response.
  - Also cancel any grant made in that cycle.
  - Writes are never aborted; a WR in progress completes and responds.
- rdy_in = 0: no state change; mem_wr is forced to 0.
- Reset: state IDLE, last_grant = NUM_CH-1, and all outputs 0 (mem_a, mem_dout, mem_wr, ch_resp_valid, ch_resp_data).

## Timing
- Grant cycle t is in IDLE.
- Read of N bytes: addresses at t+1..t+N; sample at t+N+1; resp_valid at t+N+2.
  - Word load latency is 6 cycles.
- Write of N bytes: bytes at t+1..t+N; resp_valid at t+N+1.
  - Each IO-stall cycle adds 1.
- Earliest next grant is the cycle after DONE.
- A client may drop valid at most in the cycle after resp_valid.
- A client must not re-raise valid in the same cycle it sees resp_valid.
- Simultaneous requests are served in round-robin order; no channel waits more than NUM_CH-1 transactions.
- Address wrap: addr+k wraps modulo 2^ADDR_WIDTH.

## Structure
- util.v gets:
  - `MEM_SIZE_B/H/W size codes.
  - `IO_ADDR_HI pattern 2'b11.
  - Existing `ADDR_WIDTH/`VAL_WIDTH.
- Sub-module rr_arbiter (NUM_CH): request vector and last_grant in, one-hot grant and grant index out; combinational.

## Test plan
- Word load, ch1, addr 0x100, RAM bytes 11 22 33 44 → mem_a 0x100..0x103 at t+1..t+4; ch_resp_data = 0x44332211 at t+6.
- Signed byte load of 0x80 → 0xFFFFFF80; unsigned → 0x00000080.
- Half store 0xBEEF to 0x202 → mem_wr=1 with (0x202,EF), (0x203,BE); resp_valid at t+3; 0x204 untouched.
- ch0 and ch1 held valid together for 4 transactions → grants alternate 0,1,0,1.
- clear_in during ch1 word load at t+3 → no resp_valid, IDLE at t+4. Same during a store → store completes and responds.
- Byte store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those cycles, then one write; resp_valid delayed by 3.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared codes and helpers for the byte-serial memory controller.
// Size codes, IO address pattern, FSM states and load extension.
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } mc_state_t;

  // Index of the last byte of an access.
  function automatic logic [1:0] size_last(
    input logic [1:0] sz
  );
    logic [1:0] r;
    unique case (1'b1)
      sz == MEM_SIZE_B: r = 2'd0;
      sz == MEM_SIZE_H: r = 2'd1;
      default:          r = 2'd3;
    endcase
    return r;
  endfunction

  // Zero- or sign-extend a byte/half load; words pass through.
  function automatic logic [31:0] load_ext(
    input logic [31:0] d,
    input logic [1:0]  sz,
    input logic        sgn
  );
    logic [31:0] r;
    unique case (1'b1)
      sz == MEM_SIZE_B:
        r = {{24{sgn & d[7]}}, d[7:0]};
      sz == MEM_SIZE_H:
        r = {{16{sgn & d[15]}}, d[15:0]};
      default:
        r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester after last_grant wins.
// Purely combinational; one-hot and index forms of the grant.
module mem_ctrl_rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IW = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     grant_idx
);

  // Scan offsets from far to near so the nearest requester wins.
  always_comb begin
    int j;
    grant = '0;
    grant_idx = '0;
    j = 0;
    for (int off = NUM_CH; off >= 1; off--) begin
      j = (int'(last_grant) + off) % NUM_CH;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates clients, serialises to byte RAM.
// Loads are extended; stores are byte-serial; flush kills reads.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int VAL_WIDTH = 32,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         clear_in,
  input  logic [NUM_CH-1:0]            ch_req_valid,
  input  logic [NUM_CH-1:0]            ch_req_wr,
  input  logic [2*NUM_CH-1:0]          ch_req_size,
  input  logic [NUM_CH-1:0]            ch_req_signed,
  input  logic [ADDR_WIDTH*NUM_CH-1:0] ch_req_addr,
  input  logic [VAL_WIDTH*NUM_CH-1:0]  ch_req_wdata,
  output logic [NUM_CH-1:0]            ch_resp_valid,
  output logic [VAL_WIDTH-1:0]         ch_resp_data,
  input  logic [7:0]                   mem_din,
  output logic [7:0]                   mem_dout,
  output logic [ADDR_WIDTH-1:0]        mem_a,
  output logic                         mem_wr,
  input  logic                         io_buffer_full
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [ADDR_WIDTH-1:0] req_addr  [NUM_CH];
  logic [VAL_WIDTH-1:0]  req_wdata [NUM_CH];
  logic [1:0]            req_size  [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign req_addr[i]  = ch_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_wdata[i] = ch_req_wdata[i*VAL_WIDTH +: VAL_WIDTH];
    assign req_size[i]  = ch_req_size[2*i +: 2];
  end

  mc_state_t             state;
  logic [IW-1:0]         cur;
  logic [IW-1:0]         last_grant;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [1:0]            last_q;
  logic                  sgn_q;
  logic                  is_wr;
  logic [VAL_WIDTH-1:0]  wdata_q;
  logic [VAL_WIDTH-1:0]  data_q;
  logic [2:0]            cnt;
  logic [ADDR_WIDTH-1:0] mem_a_q;
  logic [7:0]            dout_q;
  logic                  wr_q;
  logic [NUM_CH-1:0]     resp_v_q;
  logic [VAL_WIDTH-1:0]  resp_d_q;

  logic [NUM_CH-1:0] gnt_oh;
  logic [IW-1:0]     gnt_idx;

  mem_ctrl_rr_arbiter #(
    .NUM_CH(NUM_CH),
    .IW(IW)
  ) u_arb (
    .req(ch_req_valid),
    .last_grant(last_grant),
    .grant(gnt_oh),
    .grant_idx(gnt_idx)
  );

  logic       any_req;
  logic       cancel;
  logic       flush_rd;
  logic       kill;
  logic       io_stall;
  logic [2:0] nxt;
  logic [2:0] prv;
  logic [2:0] nbytes;

  assign any_req = |gnt_oh;
  assign cancel = clear_in & FLUSH_MASK[gnt_idx]
                & ~ch_req_wr[gnt_idx];
  assign flush_rd = clear_in & FLUSH_MASK[cur] & ~is_wr
                  & ((state == ST_RD) | (state == ST_DONE));
  assign kill = flush_rd & rdy_in & (state == ST_DONE);
  assign io_stall = (state == ST_WR)
                  & (mem_a_q[17:16] == IO_ADDR_HI)
                  & io_buffer_full;
  assign nxt = cnt + 3'd1;
  assign prv = cnt - 3'd1;
  assign nbytes = {1'b0, last_q} + 3'd1;

  logic [VAL_WIDTH-1:0] rd_full;

  // Read data with the byte arriving this cycle merged in.
  always_comb begin
    rd_full = data_q;
    if (cnt != 3'd0)
      rd_full[{prv[1:0], 3'b000} +: 8] = mem_din;
  end

  assign mem_a = mem_a_q;
  assign mem_dout = dout_q;
  assign mem_wr = wr_q & rdy_in & ~io_stall;
  assign ch_resp_valid = resp_v_q & {NUM_CH{~kill}};
  assign ch_resp_data = resp_d_q;

  // Transaction sequencer: grant, byte serialisation, response.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
      cur <= '0;
      last_grant <= IW'(NUM_CH - 1);
      addr_q <= '0;
      size_q <= '0;
      last_q <= '0;
      sgn_q <= 1'b0;
      is_wr <= 1'b0;
      wdata_q <= '0;
      data_q <= '0;
      cnt <= '0;
      mem_a_q <= '0;
      dout_q <= '0;
      wr_q <= 1'b0;
      resp_v_q <= '0;
      resp_d_q <= '0;
    end else if (rdy_in) begin
      unique case (state)
        ST_IDLE: begin
          if (any_req && !cancel) begin
            cur <= gnt_idx;
            addr_q <= req_addr[gnt_idx];
            size_q <= req_size[gnt_idx];
            last_q <= size_last(req_size[gnt_idx]);
            sgn_q <= ch_req_signed[gnt_idx];
            is_wr <= ch_req_wr[gnt_idx];
            wdata_q <= req_wdata[gnt_idx];
            data_q <= '0;
            cnt <= '0;
            mem_a_q <= req_addr[gnt_idx];
            if (ch_req_wr[gnt_idx]) begin
              state <= ST_WR;
              dout_q <= req_wdata[gnt_idx][7:0];
              wr_q <= 1'b1;
            end else begin
              state <= ST_RD;
              wr_q <= 1'b0;
            end
          end
        end
        ST_RD: begin
          if (flush_rd) begin
            state <= ST_IDLE;
            mem_a_q <= '0;
          end else begin
            if (cnt != 3'd0)
              data_q <= rd_full;
            if (cnt == nbytes) begin
              state <= ST_DONE;
              resp_v_q <= NUM_CH'(1) << cur;
              resp_d_q <= load_ext(rd_full, size_q, sgn_q);
            end else if (nxt == nbytes) begin
              mem_a_q <= '0;
            end else begin
              mem_a_q <= addr_q + ADDR_WIDTH'(nxt);
            end
            cnt <= nxt;
          end
        end
        ST_WR: begin
          if (!io_stall) begin
            if (cnt[1:0] == last_q) begin
              state <= ST_DONE;
              resp_v_q <= NUM_CH'(1) << cur;
              resp_d_q <= '0;
              wr_q <= 1'b0;
              mem_a_q <= '0;
              dout_q <= '0;
            end else begin
              mem_a_q <= addr_q + ADDR_WIDTH'(nxt);
              dout_q <= wdata_q[{nxt[1:0], 3'b000} +: 8];
              cnt <= nxt;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          resp_v_q <= '0;
          resp_d_q <= '0;
          if (!flush_rd)
            last_grant <= cur;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, transaction-level reference
// memory, response scoreboard and directed timing checks.
module tb_mem_ctrl;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;

  typedef struct {
    int          ch;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic [1:0]  ch_req_valid;
  logic [1:0]  ch_req_wr;
  logic [3:0]  ch_req_size;
  logic [1:0]  ch_req_signed;
  logic [63:0] ch_req_addr;
  logic [63:0] ch_req_wdata;
  logic [1:0]  ch_resp_valid;
  logic [31:0] ch_resp_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  mem_ctrl #(
    .NUM_CH(2),
    .ADDR_WIDTH(32),
    .VAL_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .clear_in(clear_in),
    .ch_req_valid(ch_req_valid),
    .ch_req_wr(ch_req_wr),
    .ch_req_size(ch_req_size),
    .ch_req_signed(ch_req_signed),
    .ch_req_addr(ch_req_addr),
    .ch_req_wdata(ch_req_wdata),
    .ch_resp_valid(ch_resp_valid),
    .ch_resp_data(ch_resp_data),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_a(mem_a),
    .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int m_last = 1;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  exp_t       exp_q   [$];
  op_t        cur_ops [2];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-wide RAM: read data one cycle after its address.
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic at_cycle(input int target);
    do @(negedge clk); while (cyc < target);
  endtask

  function automatic op_t mk(input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic [31:0] a,
                             input logic [31:0] wd);
    op_t o;
    o.wr = wr;
    o.sz = sz;
    o.sgn = sgn;
    o.addr = a;
    o.wd = wd;
    return o;
  endfunction

  // Reference semantics of one access against ref_mem.
  function automatic logic [31:0] ref_apply(input op_t o);
    int n;
    logic [31:0] v;
    n = (o.sz == 2'd0) ? 1 : (o.sz == 2'd1) ? 2 : 4;
    v = 32'd0;
    if (o.wr) begin
      for (int k = 0; k < n; k++)
        ref_mem[o.addr + 32'(k)] = o.wd[8*k +: 8];
      return 32'd0;
    end
    for (int k = 0; k < n; k++)
      v = v + (32'(ref_rd(o.addr + 32'(k))) << (8 * k));
    if (o.sgn && n == 1 && v >= 32'd128)
      v = v + 32'hFFFF_FF00;
    if (o.sgn && n == 2 && v >= 32'd32768)
      v = v + 32'hFFFF_0000;
    return v;
  endfunction

  // Present cur_ops on the masked channels at once; predict order.
  task automatic issue_round(input logic [1:0] mask);
    int order[$];
    int c;
    int guard;
    logic [1:0] pend;
    exp_t e;
    for (int off = 1; off <= 2; off++) begin
      c = (m_last + off) % 2;
      if (mask[c]) order.push_back(c);
    end
    foreach (order[i]) begin
      e.ch = order[i];
      e.data = ref_apply(cur_ops[order[i]]);
      exp_q.push_back(e);
      m_last = order[i];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      ch_req_wr[k] = cur_ops[k].wr;
      ch_req_size[2*k +: 2] = cur_ops[k].sz;
      ch_req_signed[k] = cur_ops[k].sgn;
      ch_req_addr[32*k +: 32] = cur_ops[k].addr;
      ch_req_wdata[32*k +: 32] = cur_ops[k].wd;
    end
    ch_req_valid = mask;
    pend = mask;
    guard = 0;
    while (pend != 2'b00 && guard < 200) begin
      @(negedge clk);
      guard++;
      for (int k = 0; k < 2; k++)
        if (ch_resp_valid[k] && pend[k]) begin
          ch_req_valid[k] = 1'b0;
          pend[k] = 1'b0;
        end
    end
    ch_req_valid = 2'b00;
    chk("round_done", 32'(pend), 32'd0);
  endtask

  // Scoreboard monitor: every response must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_in && rdy_in) begin
      for (int c = 0; c < 2; c++)
        if (ch_resp_valid[c]) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_resp: ch %0d data %h want none",
                     c, ch_resp_data);
          end else begin
            e = exp_q.pop_front();
            chk("resp_ch", 32'(c), 32'(e.ch));
            chk("resp_data", ch_resp_data, e.data);
          end
        end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit hit, got running want done");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int nresp;
    logic [1:0] m;
    rst_in = 1'b1;
    rdy_in = 1'b1;
    clear_in = 1'b0;
    io_buffer_full = 1'b0;
    ch_req_valid = '0;
    ch_req_wr = '0;
    ch_req_size = '0;
    ch_req_signed = '0;
    ch_req_addr = '0;
    ch_req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_resp_v", 32'(ch_resp_valid), 32'd0);
    chk("rst_resp_d", ch_resp_data, 32'd0);
    @(posedge clk);
    #1;
    rst_in = 1'b0;

    // Word load on ch1 with known bytes and exact timing.
    for (int k = 0; k < 4; k++) begin
      ram[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
      ref_mem[32'h100 + 32'(k)] = 8'(8'h11 * (k + 1));
    end
    cur_ops[0] = mk(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    cur_ops[1] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    fork
      issue_round(2'b10);
      begin
        int tt;
        @(posedge clk);
        #1;
        tt = cyc;
        for (int k = 1; k <= 4; k++) begin
          at_cycle(tt + k);
          chk("ld_addr", mem_a, 32'h100 + 32'(k - 1));
          chk("ld_wr", 32'(mem_wr), 32'd0);
        end
        at_cycle(tt + 5);
        chk("ld_early", 32'(ch_resp_valid), 32'd0);
        at_cycle(tt + 6);
        chk("ld_resp", 32'(ch_resp_valid), 32'd2);
      end
    join

    // Signed and unsigned byte loads of 0x80.
    ram[32'h150] = 8'h80;
    ref_mem[32'h150] = 8'h80;
    cur_ops[0] = mk(1'b0, 2'd0, 1'b1, 32'h150, 32'h0);
    issue_round(2'b01);
    cur_ops[1] = mk(1'b0, 2'd0, 1'b0, 32'h150, 32'h0);
    issue_round(2'b10);
    cur_ops[0] = mk(1'b0, 2'd1, 1'b1, 32'h14F, 32'h0);
    issue_round(2'b01);

    // Half store 0xBEEF to 0x202.
    cur_ops[1] = mk(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_BEEF);
    fork
      issue_round(2'b10);
      begin
        int tt;
        @(posedge clk);
        #1;
        tt = cyc;
        at_cycle(tt + 1);
        chk("st_wr0", 32'(mem_wr), 32'd1);
        chk("st_a0", mem_a, 32'h202);
        chk("st_d0", 32'(mem_dout), 32'hEF);
        at_cycle(tt + 2);
        chk("st_wr1", 32'(mem_wr), 32'd1);
        chk("st_a1", mem_a, 32'h203);
        chk("st_d1", 32'(mem_dout), 32'hBE);
        at_cycle(tt + 3);
        chk("st_resp", 32'(ch_resp_valid), 32'd2);
      end
    join
    chk("st_untouched", 32'(ram_rd(32'h204)),
        32'(init_byte(32'h204)));
    cur_ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    issue_round(2'b01);

    // Round-robin: both channels, then a lone ch0, then both.
    cur_ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    cur_ops[1] = mk(1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
    issue_round(2'b11);
    issue_round(2'b11);
    issue_round(2'b01);
    issue_round(2'b11);

    // Flush during a ch1 word load: no response, back to idle.
    @(posedge clk);
    #1;
    t = cyc;
    ch_req_wr = 2'b00;
    ch_req_size[3:2] = 2'd2;
    ch_req_addr[63:32] = 32'h400;
    ch_req_valid = 2'b10;
    at_cycle(t + 2);
    @(posedge clk);
    #1;
    clear_in = 1'b1;
    ch_req_valid = 2'b00;
    nresp = 0;
    @(negedge clk);
    if (ch_resp_valid != 2'b00) nresp++;
    @(posedge clk);
    #1;
    clear_in = 1'b0;
    @(negedge clk);
    chk("fl_idle_a", mem_a, 32'd0);
    chk("fl_idle_wr", 32'(mem_wr), 32'd0);
    repeat (6) begin
      @(negedge clk);
      if (ch_resp_valid != 2'b00) nresp++;
    end
    chk("fl_no_resp", 32'(nresp), 32'd0);

    // Flush during a store: store still completes and responds.
    cur_ops[1] = mk(1'b1, 2'd2, 1'b0, 32'h500, 32'hCAFE_F00D);
    fork
      issue_round(2'b10);
      begin
        repeat (3) begin
          @(posedge clk);
          #1;
        end
        clear_in = 1'b1;
        @(posedge clk);
        #1;
        clear_in = 1'b0;
      end
    join
    cur_ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h500, 32'h0);
    issue_round(2'b01);

    // IO byte store with the buffer full for three cycles.
    cur_ops[0] = mk(1'b1, 2'd0, 1'b0, 32'h3_0000, 32'h5A);
    fork
      issue_round(2'b01);
      begin
        int tt;
        @(posedge clk);
        #1;
        tt = cyc;
        io_buffer_full = 1'b1;
        for (int k = 1; k <= 3; k++) begin
          at_cycle(tt + k);
          chk("io_stall_wr", 32'(mem_wr), 32'd0);
        end
        @(posedge clk);
        #1;
        io_buffer_full = 1'b0;
        @(negedge clk);
        chk("io_wr", 32'(mem_wr), 32'd1);
        chk("io_a", mem_a, 32'h3_0000);
        chk("io_early", 32'(ch_resp_valid), 32'd0);
        at_cycle(tt + 5);
        chk("io_resp", 32'(ch_resp_valid), 32'd1);
      end
    join
    cur_ops[1] = mk(1'b0, 2'd0, 1'b0, 32'h3_0000, 32'h0);
    issue_round(2'b10);

    // rdy_in low for two cycles in the middle of a word store.
    cur_ops[1] = mk(1'b1, 2'd2, 1'b0, 32'h600, 32'h1234_5678);
    fork
      issue_round(2'b10);
      begin
        int tt;
        @(posedge clk);
        #1;
        tt = cyc;
        at_cycle(tt + 1);
        chk("rdy_a0", mem_a, 32'h600);
        @(posedge clk);
        #1;
        rdy_in = 1'b0;
        @(negedge clk);
        chk("rdy_wr_lo", 32'(mem_wr), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rdy_hold_a", mem_a, 32'h601);
        @(posedge clk);
        #1;
        rdy_in = 1'b1;
        @(negedge clk);
        chk("rdy_wr_hi", 32'(mem_wr), 32'd1);
        at_cycle(tt + 6);
        chk("rdy_early", 32'(ch_resp_valid), 32'd0);
        at_cycle(tt + 7);
        chk("rdy_resp", 32'(ch_resp_valid), 32'd2);
      end
    join
    cur_ops[0] = mk(1'b0, 2'd2, 1'b0, 32'h600, 32'h0);
    issue_round(2'b01);

    // Address wrap at the top of the address space.
    cur_ops[0] = mk(1'b1, 2'd1, 1'b0, 32'h0, 32'h0000_A55A);
    issue_round(2'b01);
    cur_ops[0] = mk(1'b0, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h0);
    issue_round(2'b01);

    // Random mixed traffic over a small overlapping window.
    for (int r = 0; r < 80; r++) begin
      m = 2'($urandom_range(1, 3));
      for (int c = 0; c < 2; c++)
        cur_ops[c] = mk(1'($urandom), 2'($urandom_range(0, 2)),
                        1'($urandom),
                        32'h1000 + 32'($urandom_range(0, 23)),
                        $urandom);
      issue_round(m);
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
